tdp_ram_port_arbiter: RTL and testbench

- Shares one port of the 1024x72 true-dual-port RAM block between NUM_REQ requesters using a round-robin request/grant handshake.
- Contains a clear engine that zero-fills the whole RAM on command and blocks requesters while it runs.
- Sits between the cp_cluster compute units and port A of the RAM. Port B stays with its own single owner.

---
 rtl/tdp_ram_port_arbiter.sv | 73 +++++++
 tb/tb_tdp_ram_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_port_arbiter.sv
// tdp_ram_port_arbiter: round-robin sharing of one RAM port plus a zero-fill clear engine
module tdp_ram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 72
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_dout
);
    localparam int RR_W = $clog2(NUM_REQ);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t              state, state_nx;
    logic [RR_W-1:0]     rr, gidx;
    logic [ADDR_W-1:0]   cnt, addr_q;
    logic [NUM_REQ-1:0]  rvalid_q;
    logic                done_q, hit, acc;
    // first requester at or after rr, wrapping
    always_comb begin
        hit  = 1'b0;
        gidx = rr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && req[(int'(rr) + k) % NUM_REQ]) begin
                hit  = 1'b1;
                gidx = RR_W'((int'(rr) + k) % NUM_REQ);
            end
        end
    end
    // reset gates the grant so nothing reaches the RAM while rst_n is low
    always_comb begin
        acc      = rst_n && state == IDLE && !clr_start && hit;
        gnt      = acc ? (NUM_REQ'(1) << gidx) : '0;
        ram_we   = state == CLEAR || (acc && req_we[gidx]);
        ram_addr = state == CLEAR ? cnt : acc ? req_addr[gidx*ADDR_W +: ADDR_W] : addr_q;
        ram_din  = acc ? req_wdata[gidx*DATA_W +: DATA_W] : '0;
        state_nx = state == IDLE ? (clr_start ? CLEAR : IDLE) : (&cnt ? IDLE : CLEAR);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= '0;
            cnt      <= '0;
            addr_q   <= '0;
            rvalid_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            addr_q   <= ram_addr;
            rvalid_q <= gnt & ~req_we;
            done_q   <= state == CLEAR && &cnt;
            cnt      <= state == CLEAR ? cnt + 1'b1 : '0;
            if (acc)
                rr <= gidx == RR_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
        end
    end
    assign clr_busy = state == CLEAR;
    assign clr_done = done_q;
    assign rvalid   = rvalid_q;
    assign rdata    = ram_dout;
endmodule

// File: tb/tb_tdp_ram_port_arbiter.sv
// tb_tdp_ram_port_arbiter: randomized scenarios against a behavioural memory and rotation model
module tb_tdp_ram_port_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0, req_we = '0;
    logic [39:0]  req_addr = '0;
    logic [287:0] req_wdata = '0;
    logic         clr_start = 1'b0;
    logic [3:0]   gnt, rvalid;
    logic [71:0]  rdata, ram_din, ram_dout;
    logic [9:0]   ram_addr;
    logic         clr_busy, clr_done, ram_we;
    logic         pre = 1'b1;
    logic [71:0]  mem [1024];
    logic [71:0]  ref_mem [1024];
    logic [3:0]   exp_rv = '0;
    logic [71:0]  exp_rd = '0;
    int           m_rr = 0;
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    tdp_ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    function automatic logic [71:0] init_val(input int i);
        return (i == 5) ? 72'h0AB : {8'h5A, 32'(i) * 32'h9E3779B1, 32'(i) + 32'h1};
    endfunction

    // address-registered RAM behind port A
    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [39:0] rnd_a();
        logic [39:0] v;
        for (int i = 0; i < 4; i++) v[i*10 +: 10] = 10'($urandom_range(0, 31));
        return v;
    endfunction

    function automatic logic [287:0] rnd_d();
        logic [287:0] v;
        for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic step(input logic [3:0] r, input logic [3:0] we, input logic [39:0] a,
                        input logic [287:0] d, input logic clr);
        int g;
        logic [3:0] eg;
        logic [9:0] ad;
        @(negedge clk);
        checks++;
        if (rvalid !== exp_rv) begin failures++; $display("FAIL rvalid: got %b exp %b", rvalid, exp_rv); end
        if (exp_rv != 0) begin
            checks++;
            if (rdata !== exp_rd) begin failures++; $display("FAIL rdata: got %h exp %h", rdata, exp_rd); end
        end
        req = r; req_we = we; req_addr = a; req_wdata = d; clr_start = clr;
        #1;
        g  = clr ? -1 : pick(r, m_rr);
        eg = g < 0 ? 4'b0 : 4'b1 << g;
        checks++;
        if (gnt !== eg) begin failures++; $display("FAIL gnt: got %b exp %b", gnt, eg); end
        exp_rv = '0;
        if (g >= 0) begin
            ad = a[g*10 +: 10];
            checks++;
            if (ram_addr !== ad || ram_we !== we[g] || (we[g] && ram_din !== d[g*72 +: 72])) begin
                failures++;
                $display("FAIL ram_port: got addr %h we %b exp addr %h we %b", ram_addr, ram_we, ad, we[g]);
            end
            if (we[g]) ref_mem[ad] = d[g*72 +: 72];
            else begin exp_rv[g] = 1'b1; exp_rd = ref_mem[ad]; end
            m_rr = (g + 1) % 4;
        end else begin
            checks++;
            if (ram_we !== 1'b0) begin failures++; $display("FAIL idle_we: got %b exp 0", ram_we); end
        end
    endtask

    task automatic one(input int i, input logic we, input logic [9:0] a, input logic [71:0] d);
        logic [39:0]  av = rnd_a();
        logic [287:0] dv = rnd_d();
        logic [3:0]   wv = 4'($urandom());
        av[i*10 +: 10] = a;
        dv[i*72 +: 72] = d;
        wv[i] = we;
        step(4'b1 << i, wv, av, dv, 1'b0);
    endtask

    task automatic idle();
        step(4'b0, 4'($urandom()), rnd_a(), rnd_d(), 1'b0);
    endtask

    task automatic run_clear(input int restart_at, input int reset_at);
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            clr_start = (k == restart_at);
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({gnt, rvalid, clr_busy, clr_done, ram_we} !== 11'b0 || ram_addr !== '0 || ram_din !== '0) begin
                    failures++;
                    $display("FAIL reset_mid_clear: got gnt %b rv %b busy %b done %b we %b addr %h exp all 0",
                             gnt, rvalid, clr_busy, clr_done, ram_we, ram_addr);
                end
                m_rr = 0;
                exp_rv = '0;
                return;
            end
            #1;
            checks++;
            if (gnt !== 4'b0 || rvalid !== 4'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0 ||
                ram_we !== 1'b1 || ram_din !== '0 || ram_addr !== 10'(k - 1)) begin
                failures++;
                $display("FAIL clear_cycle %0d: got busy %b we %b addr %h gnt %b done %b exp busy 1 we 1 addr %h gnt 0 done 0",
                         k, clr_busy, ram_we, ram_addr, gnt, clr_done, 10'(k - 1));
            end
            ref_mem[k-1] = '0;
        end
        clr_start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        req = 4'b1111; clr_start = 1'b1;
        @(posedge clk);
        #1 pre = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, rvalid, clr_busy, clr_done, ram_we} !== 11'b0 || ram_addr !== '0 || ram_din !== '0) begin
            failures++;
            $display("FAIL reset: got gnt %b rv %b busy %b done %b we %b addr %h exp all 0",
                     gnt, rvalid, clr_busy, clr_done, ram_we, ram_addr);
        end
        req = '0; clr_start = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        one(0, 1'b0, 10'd5, 72'h0);
        idle();
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 8; c++) step(4'b1111, 4'b0000, rnd_a(), rnd_d(), 1'b0);
        idle();
    endtask

    task automatic test_read_after_write();
        one(2, 1'b1, 10'd1023, 72'h123456789ABCDEF012);
        one(0, 1'b0, 10'd1023, 72'h0);
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) step(4'($urandom()), 4'($urandom()), rnd_a(), rnd_d(), 1'b0);
    endtask

    task automatic test_clear();
        one(1, 1'b0, 10'd7, 72'h0);
        step(4'b0011, 4'b0000, rnd_a(), rnd_d(), 1'b1);
        run_clear(300, 0);
        step(4'b0011, 4'b0000, rnd_a(), rnd_d(), 1'b0);
        checks++;
        if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_done_pulse: got done %b busy %b exp done 1 busy 0", clr_done, clr_busy);
        end
        idle();
        checks++;
        if (clr_done !== 1'b0) begin failures++; $display("FAIL clr_done_width: got %b exp 0", clr_done); end
        one(0, 1'b0, 10'd0, 72'h0);
        one(3, 1'b0, 10'd512, 72'h0);
        one(2, 1'b0, 10'd1023, 72'h0);
        idle();
    endtask

    task automatic test_reset_mid_clear();
        one(1, 1'b1, 10'd100, {8'hC3, 64'($urandom()) | 64'h1});
        one(3, 1'b1, 10'd700, {8'h3C, 64'($urandom())});
        idle();
        step(4'b0000, 4'b0000, rnd_a(), rnd_d(), 1'b1);
        run_clear(0, 500);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle();
            checks++;
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
                failures++;
                $display("FAIL no_done_after_reset: got done %b busy %b exp 0 0", clr_done, clr_busy);
            end
        end
        one(2, 1'b0, 10'd100, 72'h0);
        one(0, 1'b0, 10'd700, 72'h0);
        one(1, 1'b0, 10'd499, 72'h0);
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_after_write();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
